load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 20 ++
 rtl/lsu_align.sv | 42 ++++
 rtl/load_store_unit.sv | 108 ++++++++++
 tb/tb_load_store_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and the
// default data-memory byte-address width.
package lsu_pkg;

  localparam int unsigned MEM_ADDR_BITS = 12;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE,
    RMW_RD,
    RMW_WR,
    DONE
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Little-endian lane handling: extracts and extends the addressed lane of a
// loaded word, and merges store data into the old word for sub-word stores.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{lane_i, 3'b000} +: 8];
    half_sel = rdata_i[{lane_i[1], 4'b0000} +: 16];

    load_o  = rdata_i;
    merge_o = wdata_i;
    case (size_i)
      SZ_B: begin
        load_o = uns_i ? {24'h000000, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        merge_o = rdata_i;
        merge_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SZ_H: begin
        load_o = uns_i ? {16'h0000, half_sel} : {{16{half_sel[15]}}, half_sel};
        merge_o = rdata_i;
        merge_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      default: begin
        load_o  = rdata_i;
        merge_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-request load/store unit in front of a word-wide data memory; sub-word
// stores are done as read-modify-write, illegal requests complete with an error.
module load_store_unit #(
  parameter int unsigned MEM_ADDR_BITS = lsu_pkg::MEM_ADDR_BITS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] addr,
  output logic [31:0] mem_write_word,
  input  logic [31:0] mem_read_word
);
  import lsu_pkg::*;

  lsu_state_e  state_q, state_d;
  logic        we_q, uns_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, data_q;
  logic        accept, req_bad, mem_state;
  logic [31:0] load_ext, store_merged;

  assign accept = req_valid && (state_q == IDLE);

  always_comb begin
    req_bad = 1'b0;
    if (req_size == 2'b11)                          req_bad = 1'b1;
    if (req_size == SZ_H && req_addr[0])            req_bad = 1'b1;
    if (req_size == SZ_W && req_addr[1:0] != 2'b00) req_bad = 1'b1;
    if ((req_addr >> MEM_ADDR_BITS) != '0)          req_bad = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_bad)              state_d = DONE;
          else if (!req_we)         state_d = LOAD;
          else if (req_size == SZ_W) state_d = STORE;
          else                      state_d = RMW_RD;
        end
      end
      LOAD, STORE, RMW_WR: state_d = DONE;
      RMW_RD:              state_d = RMW_WR;
      DONE:                state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= req_bad;
      end
      if (state_q == LOAD || state_q == RMW_RD) data_q <= mem_read_word;
    end
  end

  lsu_align u_align (
    .size_i  (size_q),
    .uns_i   (uns_q),
    .lane_i  (addr_q[1:0]),
    .rdata_i (data_q),
    .wdata_i (wdata_q),
    .load_o  (load_ext),
    .merge_o (store_merged)
  );

  // All outputs are Moore decodes of state_q, so async reset zeroes them at once.
  assign mem_state      = (state_q == LOAD) || (state_q == STORE) ||
                          (state_q == RMW_RD) || (state_q == RMW_WR);
  assign req_ready      = (state_q == IDLE);
  assign resp_valid     = (state_q == DONE);
  assign resp_err       = (state_q == DONE) && err_q;
  assign resp_rdata     = ((state_q == DONE) && !we_q && !err_q) ? load_ext : '0;
  assign MemRead        = (state_q == LOAD) || (state_q == RMW_RD);
  assign MemWrite       = (state_q == STORE) || (state_q == RMW_WR);
  assign addr           = mem_state ? {addr_q[31:2], 2'b00} : '0;
  assign mem_write_word = (state_q == STORE)  ? wdata_q :
                          (state_q == RMW_WR) ? store_merged : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: the driver queues expected responses,
// a negedge monitor pops and compares data, error and latency.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, MemRead, MemWrite;
  logic [31:0] resp_rdata, addr, mem_write_word, mem_read_word;

  load_store_unit #(.MEM_ADDR_BITS(12)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .MemRead(MemRead),
    .MemWrite(MemWrite), .addr(addr), .mem_write_word(mem_write_word),
    .mem_read_word(mem_read_word)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  assign mem_read_word = MemRead ? mem[addr[11:2]] : '0;
  always @(posedge clk) if (MemWrite) mem[addr[11:2]] <= mem_write_word;

  typedef struct { logic [31:0] rdata; logic err; int unsigned lat; } exp_t;
  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;

  exp_t        exp_q[$];
  int unsigned acc_q[$];
  wr_t         wlog[$];
  int unsigned n_rd = 0;
  int unsigned cyc = 0;
  int unsigned n_chk = 0, n_pass = 0, n_resp = 0;
  logic        strobe_seen = 1'b0, both_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h", nm, act, req);
  endtask

  // Monitor: strobes, write log, responses against scoreboard, accept times.
  always @(negedge clk) begin
    if (rst_n) begin
      if (MemRead && MemWrite) both_seen = 1'b1;
      if (MemRead || MemWrite) strobe_seen = 1'b1;
      if (MemRead) n_rd++;
      if (MemWrite) wlog.push_back('{addr, mem_write_word});
      if (resp_valid) begin
        n_resp++;
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          chk("unexpected_resp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          int unsigned a;
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
          chk("latency", cyc - a, e.lat);
          if (e.err) chk("err_no_mem_access", {31'd0, strobe_seen}, 32'd0);
        end
      end
      if (req_valid && req_ready) begin
        acc_q.push_back(cyc);
        strobe_seen = 1'b0;
      end
    end
  end

  // Called at posedge+1: waits for ready, presents one request for one accept.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee, input int unsigned lat);
    int unsigned n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    exp_q.push_back('{er, ee, lat});
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < 30) begin @(posedge clk); #1; n++; end
    if (exp_q.size() != 0) begin
      chk("resp_timeout", exp_q.size(), 32'd0);
      exp_q.delete(); acc_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned r0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[32'h200 >> 2] = 32'h11223344;
    mem[32'h040 >> 2] = 32'h0000FF80;
    mem[32'h300 >> 2] = 32'h11223344;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_mem_strobes", {30'd0, MemRead, MemWrite}, 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_wdata", mem_write_word, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Word store then word load at 0x100.
    wlog.delete();
    issue(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    wait_done();
    chk("sw_write_count", wlog.size(), 32'd1);
    if (wlog.size() > 0) begin
      chk("sw_write_addr", wlog[0].a, 32'h100);
      chk("sw_write_data", wlog[0].d, 32'hDEADBEEF);
    end
    chk("sw_mem", mem[32'h100 >> 2], 32'hDEADBEEF);
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 2);
    wait_done();

    // Byte store into 0x11223344 via read-modify-write.
    wlog.delete(); r0 = n_rd;
    issue(1'b1, 2'b00, 1'b0, 32'h202, 32'h000000AA, 32'h0, 1'b0, 3);
    wait_done();
    chk("sb_read_count", n_rd - r0, 32'd1);
    chk("sb_write_count", wlog.size(), 32'd1);
    if (wlog.size() > 0) chk("sb_write_data", wlog[0].d, 32'h11AA3344);
    chk("sb_mem", mem[32'h200 >> 2], 32'h11AA3344);
    issue(1'b1, 2'b01, 1'b0, 32'h202, 32'h1234BEEF, 32'h0, 1'b0, 3);
    wait_done();
    chk("sh_mem", mem[32'h200 >> 2], 32'hBEEF3344);
    issue(1'b0, 2'b01, 1'b0, 32'h202, 32'h0, 32'hFFFFBEEF, 1'b0, 2);
    wait_done();

    // Sub-word loads of 0x0000FF80.
    issue(1'b0, 2'b00, 1'b0, 32'h40, 32'h0, 32'hFFFFFF80, 1'b0, 2);
    issue(1'b0, 2'b00, 1'b1, 32'h40, 32'h0, 32'h00000080, 1'b0, 2);
    issue(1'b0, 2'b01, 1'b1, 32'h40, 32'h0, 32'h0000FF80, 1'b0, 2);
    issue(1'b0, 2'b01, 1'b0, 32'h40, 32'h0, 32'hFFFFFF80, 1'b0, 2);
    issue(1'b0, 2'b00, 1'b1, 32'h41, 32'h0, 32'h000000FF, 1'b0, 2);
    issue(1'b0, 2'b01, 1'b0, 32'h42, 32'h0, 32'h00000000, 1'b0, 2);
    wait_done();

    // Error cases: no memory access, one-cycle completion.
    wlog.delete(); r0 = n_rd;
    issue(1'b0, 2'b10, 1'b0, 32'h103,  32'h0, 32'h0, 1'b1, 1);
    issue(1'b1, 2'b01, 1'b0, 32'h101,  32'h5555, 32'h0, 1'b1, 1);
    issue(1'b0, 2'b00, 1'b0, 32'h1000, 32'h0, 32'h0, 1'b1, 1);
    issue(1'b1, 2'b10, 1'b0, 32'h1000, 32'h1, 32'h0, 1'b1, 1);
    issue(1'b0, 2'b11, 1'b0, 32'h0,    32'h0, 32'h0, 1'b1, 1);
    wait_done();
    chk("err_no_reads", n_rd - r0, 32'd0);
    chk("err_no_writes", wlog.size(), 32'd0);

    // Reset pulsed while a byte store sits in RMW_WR.
    wlog.delete();
    issue(1'b1, 2'b00, 1'b0, 32'h301, 32'h00000055, 32'h0, 1'b0, 3);
    @(posedge clk); #1;
    chk("rmw_wr_reached", {31'd0, MemWrite}, 32'd1);
    rst_n = 1'b0;
    #1;
    exp_q.delete(); acc_q.delete();
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_outputs", {29'd0, resp_valid, MemRead, MemWrite}, 32'd0);
    chk("abort_addr", addr, 32'd0);
    chk("abort_wdata", mem_write_word, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_mem", mem[32'h300 >> 2], 32'h11223344);
    chk("abort_no_write", wlog.size(), 32'd0);

    // req_valid held high for 12 cycles: IDLE/LOAD/DONE repeats, 4 accepts.
    r0 = n_resp;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h100; req_wdata = '0;
    repeat (12) begin
      @(negedge clk);
      if (req_ready) exp_q.push_back('{32'hDEADBEEF, 1'b0, 2});
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_done();
    chk("stream_resp_count", n_resp - r0, 32'd4);
    chk("never_both_strobes", {31'd0, both_seen}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
